instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Multi-cycle fetch/issue sequencer that owns the PC and instruction register.
//  It feeds opcode/func to control_unit and consumes control_unit's decoded outputs
//  (reg_write, mem_read/mem_write, isBranch, JumpAddr, LabelSel).
//  From those it produces register-file and data-memory strobes and the next PC.
// PARAMETERS
//  ADDR_W  10  PC / instruction-address width; word addressed, PC steps by 1
//  DATA_W  32  instruction and register width
// PORTS
//  clk          in   1       system clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  start        in   1       leave IDLE and begin fetching at PC=0
//  instr        in   DATA_W  instruction ROM data; valid the cycle after instr_addr
//  instr_addr   out  ADDR_W  instruction ROM address (= pc)
//  opcode       out  6       ir[31:26], to control_unit
//  func         out  5       ir[4:0], to control_unit
//  reg_write    in   1       from control_unit
//  mem_read     in   1       from control_unit
//  mem_write    in   1       from control_unit
//  is_branch    in   1       from control_unit isBranch
//  jump_addr    in   1       from control_unit JumpAddr
//  label_sel    in   1       from control_unit LabelSel
//  rs_val       in   DATA_W  rs register read data
//  carry_in     in   1       ALU carry out
//  carry_we     in   1       update carry flag
//  mem_ready    in   1       data memory access complete
//  reg_we       out  1       register-file write strobe, one cycle
//  dmem_re      out  1       data-memory read strobe
//  dmem_we      out  1       data-memory write strobe
//  link_addr    out  DATA_W  zero-extended pc+1, for call link write
//  halted       out  1       high in HALT
// BEHAVIOUR
//  Reset: state=IDLE, pc=0, ir=0, carry=0, taken=0, target=0.
//   All strobes and halted are 0; outputs drop asynchronously on reset.
//  FSM: IDLE -start-> FETCH -> DECODE -> EXEC -> {MEM | WB}; MEM -mem_ready-> WB -> FETCH.
//  FETCH: drive instr_addr=pc.
//  DECODE: ir<=instr at cycle end. If instr[31:26]==6'b111111, go to HALT (sticky until rst).
//  EXEC: control inputs are valid. Register taken and target. carry<=carry_in if carry_we.
//   Next state is MEM if mem_read|mem_write and !is_branch, else WB.
//  MEM: dmem_we=mem_write; dmem_re=mem_read&!mem_write (write wins).
//   Strobes held every MEM cycle until mem_ready; mem_ready in the first cycle means 1 MEM cycle.
//  WB: reg_we=reg_write for exactly one cycle. pc<=taken?target:pc+1.
//  Latency: ALU/branch instructions take 4 cycles; load/store take 4+N, where N>=1 is the MEM cycle count.
//  Branch resolution (only when is_branch):
//   jump_addr=1 (001011 br): target=rs_val[ADDR_W-1:0]; always taken
//   label_sel=1: target=pc+1+sext(ir[25:0])
//    001000 b: always taken; 001001 bcy: taken if carry; 001010 bncy: taken if !carry
//   else: target=pc+1+sext(ir[15:0])
//    001100 bltz: taken if rs_val[31]; 001101 call: always taken, link_addr=pc+1
//    001110 bz: taken if rs_val==0; 001111 bnz: taken if rs_val!=0
//  Width rules:
//   Targets and pc+1 are truncated modulo 2^ADDR_W, so pc=2^ADDR_W-1 wraps to 0.
//   link_addr holds the pre-update pc+1 throughout WB.
//  Edge rules:
//   start is ignored outside IDLE.
//   carry_we outside EXEC is ignored.
//   Unknown opcodes behave as NOP (pc+1, no strobes).
// STRUCTURE
//  Package cpu_pkg: opcode localparams (B, BCY, BNCY, BR, BLTZ, CALL, BZ, BNZ, HALT) and state encoding.
//  Sub-module branch_cond: combinational {opcode, rs_val, carry} -> taken; unit-tested alone.
//  Remaining logic (FSM, pc/ir/carry/target registers) stays in instr_sequencer.
// TESTING
//  1. rst, then start; ROM[0]=ADD (000000/00000) -> reg_we pulses in cycle 4; pc=1 in cycle 5; no dmem strobes.
//  2. LD at pc=3, mem_ready low 2 cycles then high -> dmem_re held 3 cycles; reg_we one cycle after; pc=4.
//  3. bz with rs_val=0, ir[15:0]=16'hFFFE at pc=5 -> pc=4. Same instruction with rs_val=7 -> pc=6.
//  4. ADD with carry_we=1, carry_in=1, then bcy with offset +3 at pc=9 -> pc=13. bncy with offset +3 -> pc=10.
//  5. call at pc=20 with offset +10 -> link_addr=21 and reg_we in WB; pc=31. br with rs_val=0x3FF -> pc=1023, next sequential fetch gives pc=0.
//  6. HALT opcode -> halted=1, pc frozen, start ignored. Assert rst mid-MEM -> dmem_we drops the same cycle; state=IDLE, pc=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcodes and sequencer state encoding.
package cpu_pkg;

    localparam logic [5:0] OP_B    = 6'b001000;
    localparam logic [5:0] OP_BCY  = 6'b001001;
    localparam logic [5:0] OP_BNCY = 6'b001010;
    localparam logic [5:0] OP_BR   = 6'b001011;
    localparam logic [5:0] OP_BLTZ = 6'b001100;
    localparam logic [5:0] OP_CALL = 6'b001101;
    localparam logic [5:0] OP_BZ   = 6'b001110;
    localparam logic [5:0] OP_BNZ  = 6'b001111;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation: opcode + rs value + carry flag -> taken.
module branch_cond
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [5:0]        opcode_i,
    input  logic [DATA_W-1:0] rs_val_i,
    input  logic              carry_i,
    output logic              taken_o
);

    // Unconditional kinds are always taken; unknown opcodes never are.
    always_comb begin
        taken_o = 1'b0;
        case (opcode_i)
            OP_B, OP_BR, OP_CALL: taken_o = 1'b1;
            OP_BCY:               taken_o = carry_i;
            OP_BNCY:              taken_o = !carry_i;
            OP_BLTZ:              taken_o = rs_val_i[DATA_W-1];
            OP_BZ:                taken_o = (rs_val_i == '0);
            OP_BNZ:               taken_o = (rs_val_i != '0);
            default:              taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer owning pc and ir.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_addr,
    output logic [5:0]        opcode,
    output logic [4:0]        func,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              is_branch,
    input  logic              jump_addr,
    input  logic              label_sel,
    input  logic [DATA_W-1:0] rs_val,
    input  logic              carry_in,
    input  logic              carry_we,
    input  logic              mem_ready,
    output logic              reg_we,
    output logic              dmem_re,
    output logic              dmem_we,
    output logic [DATA_W-1:0] link_addr,
    output logic              halted
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              carry_q, carry_d;
    logic              taken_q, taken_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] offset;
    logic              cond_taken;

    assign pc_inc     = pc_q + 1'b1;
    assign instr_addr = pc_q;
    assign opcode     = ir_q[31:26];
    assign func       = ir_q[4:0];
    assign link_addr  = {{(DATA_W-ADDR_W){1'b0}}, pc_inc};
    assign halted     = (state_q == S_HALT);

    // Sign-extended immediate, truncated to pc width (targets wrap mod 2^ADDR_W).
    assign offset = label_sel ? ADDR_W'({{(DATA_W-26){ir_q[25]}}, ir_q[25:0]})
                              : ADDR_W'({{(DATA_W-16){ir_q[15]}}, ir_q[15:0]});

    branch_cond #(.DATA_W(DATA_W)) u_cond (
        .opcode_i (ir_q[31:26]),
        .rs_val_i (rs_val),
        .carry_i  (carry_q),
        .taken_o  (cond_taken)
    );

    // State, pc, ir and branch bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            carry_q  <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            carry_q  <= carry_d;
            taken_q  <= taken_d;
            target_q <= target_d;
        end
    end

    // Next-state logic and per-state strobes.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        carry_d  = carry_q;
        taken_d  = taken_q;
        target_d = target_q;
        reg_we   = 1'b0;
        dmem_re  = 1'b0;
        dmem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = instr;
                state_d = (instr[31:26] == OP_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                taken_d  = is_branch & (jump_addr | cond_taken);
                target_d = jump_addr ? rs_val[ADDR_W-1:0] : pc_inc + offset;
                if (carry_we) carry_d = carry_in;
                state_d  = ((mem_read | mem_write) & !is_branch) ? S_MEM : S_WB;
            end
            S_MEM: begin
                // A write takes priority over a read when both are decoded.
                dmem_we = mem_write;
                dmem_re = mem_read & !mem_write;
                if (mem_ready) state_d = S_WB;
            end
            S_WB: begin
                reg_we  = reg_write;
                pc_d    = taken_q ? target_q : pc_inc;
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench: stimulus pushes per-instruction expectations at fetch,
// a monitor pops and checks them when the sequencer reaches writeback.
module tb_instr_sequencer;
    import cpu_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_NOP = 6'b010101;
    localparam logic [5:0] OP_LD  = 6'b100011;
    localparam logic [5:0] OP_ST  = 6'b101011;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_addr;
    logic [5:0]    opcode;
    logic [4:0]    func;
    logic          reg_write, mem_read, mem_write, is_branch, jump_addr, label_sel;
    logic [DW-1:0] rs_val = '0;
    logic          carry_in = 1'b0;
    logic          carry_we = 1'b0;
    logic          mem_ready;
    logic          reg_we, dmem_re, dmem_we, halted;
    logic [DW-1:0] link_addr;

    logic [DW-1:0] rom [0:1023];
    int            mwait = 0;
    int            mcnt = 0;
    int            total = 0;
    int            bad = 0;

    typedef struct {
        int            pc;
        logic [DW-1:0] ins;
        logic [DW-1:0] rs;
        int            cwe, cin, noise_en, noise_val, mw;
        int            rwe, nre, nwe, lat, npc;
    } vec_t;

    typedef struct {
        int            rwe, nre, nwe, lat;
        logic [DW-1:0] link;
        logic [AW-1:0] npc;
    } exp_t;

    vec_t vq[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    instr_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .instr_addr(instr_addr),
        .opcode(opcode), .func(func), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .is_branch(is_branch), .jump_addr(jump_addr),
        .label_sel(label_sel), .rs_val(rs_val), .carry_in(carry_in), .carry_we(carry_we),
        .mem_ready(mem_ready), .reg_we(reg_we), .dmem_re(dmem_re), .dmem_we(dmem_we),
        .link_addr(link_addr), .halted(halted)
    );

    // Instruction ROM and control_unit stand-in.
    assign instr = rom[instr_addr];

    always_comb begin
        reg_write = (opcode == OP_ADD && func == 5'd0) || opcode == OP_LD || opcode == OP_CALL;
        mem_read  = (opcode == OP_LD);
        mem_write = (opcode == OP_ST);
        is_branch = (opcode[5:3] == 3'b001);
        jump_addr = (opcode == OP_BR);
        label_sel = (opcode == OP_B) || (opcode == OP_BCY) || (opcode == OP_BNCY);
    end

    // Data memory answers after mwait stall cycles of an active strobe.
    always @(posedge clk) mcnt <= (dmem_re | dmem_we) ? mcnt + 1 : 0;
    assign mem_ready = (dmem_re | dmem_we) && (mcnt == mwait);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] enc16(input logic [5:0] op, input int imm);
        return {op, 10'd0, imm[15:0]};
    endfunction

    function automatic logic [DW-1:0] enc26(input logic [5:0] op, input int imm);
        return {op, imm[25:0]};
    endfunction

    function automatic vec_t mk(input int pc, input logic [DW-1:0] ins, input logic [DW-1:0] rs,
                                input int cwe, input int cin, input int nen, input int nval,
                                input int mw, input int rwe, input int nre, input int nwe,
                                input int lat, input int npc);
        vec_t r;
        r.pc = pc; r.ins = ins; r.rs = rs; r.cwe = cwe; r.cin = cin;
        r.noise_en = nen; r.noise_val = nval; r.mw = mw; r.rwe = rwe;
        r.nre = nre; r.nwe = nwe; r.lat = lat; r.npc = npc;
        return r;
    endfunction

    task automatic wait_fetch(output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (dut.state_q == S_FETCH) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("fetch_timeout", 1, 0);
    endtask

    // Monitor: counts strobes per instruction, checks at writeback, then the new pc.
    int            m_cyc = 0, m_fcyc = 0, n_rwe = 0, n_re = 0, n_we = 0;
    logic          pend = 1'b0;
    logic [AW-1:0] pend_pc = '0;
    exp_t          m_e;

    initial begin : monitor
        forever begin
            @(negedge clk);
            m_cyc++;
            if (rst) begin
                pend = 1'b0; n_rwe = 0; n_re = 0; n_we = 0;
            end else begin
                if (pend) begin
                    chk("next_pc", instr_addr, pend_pc);
                    pend = 1'b0;
                end
                if (dut.state_q == S_FETCH) begin
                    m_fcyc = m_cyc; n_rwe = 0; n_re = 0; n_we = 0;
                end
                n_rwe += int'(reg_we);
                n_re  += int'(dmem_re);
                n_we  += int'(dmem_we);
                if (dut.state_q == S_WB) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_wb", 1, 0);
                    end else begin
                        m_e = sb.pop_front();
                        chk("reg_we_cycles", n_rwe, m_e.rwe);
                        chk("dmem_re_cycles", n_re, m_e.nre);
                        chk("dmem_we_cycles", n_we, m_e.nwe);
                        chk("latency", m_cyc - m_fcyc + 1, m_e.lat);
                        chk("link_addr", link_addr, m_e.link);
                        pend = 1'b1;
                        pend_pc = m_e.npc;
                    end
                end
            end
        end
    end

    vec_t          c;
    exp_t          e;
    logic          ok;
    logic [AW-1:0] pn;

    initial begin : stim
        for (int i = 0; i < 1024; i++) rom[i] = '0;
        //            pc    instr                      rs_val        cwe cin ne nv mw rwe re we lat npc
        vq.push_back(mk(0,    enc26(OP_ADD, 0),        32'h0,        0, 0, 0, 0, 0, 1, 0, 0, 4, 1));
        vq.push_back(mk(1,    enc26(OP_NOP, 0),        32'h0,        0, 0, 1, 1, 0, 0, 0, 0, 4, 2));
        vq.push_back(mk(2,    enc26(OP_ST, 0),         32'h0,        0, 0, 0, 0, 0, 0, 0, 1, 5, 3));
        vq.push_back(mk(3,    enc26(OP_LD, 0),         32'h0,        0, 0, 0, 0, 2, 1, 3, 0, 7, 4));
        vq.push_back(mk(4,    enc26(OP_ADD, 0),        32'h0,        0, 0, 0, 0, 0, 1, 0, 0, 4, 5));
        vq.push_back(mk(5,    enc16(OP_BZ, -2),        32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 4, 4));
        vq.push_back(mk(4,    enc26(OP_ADD, 0),        32'h0,        0, 0, 0, 0, 0, 1, 0, 0, 4, 5));
        vq.push_back(mk(5,    enc16(OP_BZ, -2),        32'h7,        0, 0, 0, 0, 0, 0, 0, 0, 4, 6));
        vq.push_back(mk(6,    enc26(OP_BCY, 2),        32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 4, 7));
        vq.push_back(mk(7,    enc26(OP_ADD, 0),        32'h0,        1, 1, 0, 0, 0, 1, 0, 0, 4, 8));
        vq.push_back(mk(8,    enc26(OP_NOP, 0),        32'h0,        0, 0, 1, 0, 0, 0, 0, 0, 4, 9));
        vq.push_back(mk(9,    enc26(OP_BCY, 3),        32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 4, 13));
        vq.push_back(mk(13,   enc26(OP_BNCY, 3),       32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 4, 14));
        vq.push_back(mk(14,   enc26(OP_ADD, 0),        32'h0,        1, 0, 0, 0, 0, 1, 0, 0, 4, 15));
        vq.push_back(mk(15,   enc26(OP_BNCY, -6),      32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 4, 10));
        vq.push_back(mk(10,   enc16(OP_BLTZ, 9),       32'h80000000, 0, 0, 0, 0, 0, 0, 0, 0, 4, 20));
        vq.push_back(mk(20,   enc16(OP_CALL, 10),      32'h0,        0, 0, 0, 0, 0, 1, 0, 0, 4, 31));
        vq.push_back(mk(31,   enc16(OP_BR, 0),         32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 4, 1023));
        vq.push_back(mk(1023, enc26(OP_ADD, 0),        32'h0,        0, 0, 0, 0, 0, 1, 0, 0, 4, 0));
        vq.push_back(mk(0,    enc16(OP_BNZ, 40),       32'h5,        0, 0, 0, 0, 0, 0, 0, 0, 4, 41));

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_instr_addr", instr_addr, 0);
        chk("rst_halted", halted, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_dmem", {dmem_re, dmem_we}, 0);
        chk("rst_opcode", opcode, 0);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        while (vq.size() > 0) begin
            c = vq.pop_front();
            wait_fetch(ok);
            if (!ok) break;
            chk("fetch_pc", instr_addr, c.pc);
            rom[c.pc] = c.ins;
            rs_val = c.rs;
            mwait = c.mw;
            pn = AW'(c.pc) + 1'b1;
            e.rwe = c.rwe; e.nre = c.nre; e.nwe = c.nwe; e.lat = c.lat;
            e.link = {{(DW-AW){1'b0}}, pn};
            e.npc = AW'(c.npc);
            sb.push_back(e);
            // Optional noise during FETCH: carry update and start must both be ignored.
            if (c.noise_en != 0) begin
                carry_we = 1'b1;
                carry_in = (c.noise_val != 0);
                start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            carry_we = (c.cwe != 0);
            carry_in = (c.cin != 0);
        end

        // HALT at pc 41: sticky, pc frozen, start ignored.
        wait_fetch(ok);
        chk("halt_fetch_pc", instr_addr, 41);
        chk("halted_before", halted, 0);
        carry_we = 1'b0;
        rom[41] = {OP_HALT, 26'd0};
        start = 1'b1;
        repeat (6) @(negedge clk);
        chk("halted", halted, 1);
        chk("halt_pc_frozen", instr_addr, 41);
        chk("halt_no_strobes", {reg_we, dmem_re, dmem_we}, 0);
        start = 1'b0;
        chk("sb_drained", sb.size(), 0);

        // Reset out of HALT, then reset in the middle of a stalled store.
        rst = 1'b1;
        #1;
        chk("rst2_halted", halted, 0);
        chk("rst2_instr_addr", instr_addr, 0);
        chk("rst2_opcode", opcode, 0);
        @(negedge clk);
        rst = 1'b0;
        rom[0] = enc26(OP_ST, 0);
        mwait = 1000;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (dmem_we) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("st_strobe_seen", ok, 1);
        @(negedge clk);
        chk("st_strobe_held", dmem_we, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_mem_dmem_we", dmem_we, 0);
        chk("rst_mid_mem_pc", instr_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_after_rst_dmem", {dmem_re, dmem_we}, 0);
        chk("idle_after_rst_reg_we", reg_we, 0);
        chk("idle_after_rst_pc", instr_addr, 0);
        chk("sb_empty_end", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
